tow_round_ctrl: RTL

//  Round sequencer for Tug-of-War. Drives clr of the push-button arbitration latch and consumes its push/tie/right result.

---
 rtl/tow_round_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tow_round_ctrl.sv
// Tug-of-War round sequencer: arms the press latch, moves the rope on each scored press, declares a winner.
// Optional FALSE_START_EN: latch open during ARM, and a press there is a foul that moves the rope against the presser.
module tow_round_ctrl #(
  parameter int POS_N       = 7,
  parameter int ARM_CYCLES  = 16,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push,
  input  logic             tie,
  input  logic             right,
  output logic             clr,
  output logic [POS_N-1:0] pos,
  output logic             win_l,
  output logic             win_r,
  output logic             busy
);

  localparam int IW    = $clog2(POS_N);
  localparam int CMAX  = (ARM_CYCLES > HOLD_CYCLES) ? ARM_CYCLES : HOLD_CYCLES;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [IW-1:0] CTR_IDX   = IW'((POS_N - 1) / 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(POS_N - 1);
  localparam logic [CW-1:0] ARM_LOAD  = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] moved;
  logic          take;
  logic          foul;
  logic          arm_clr;

`ifdef FALSE_START_EN
  // A press during ARM counts against whoever pressed.
  assign foul    = (state == S_ARM);
  assign arm_clr = 1'b0;
`else
  assign foul    = 1'b0;
  assign arm_clr = 1'b1;
`endif

  assign take = push && ((state == S_WAIT) || foul);

  // Saturating move; the end-of-bar check makes saturation unreachable in practice.
  always_comb begin
    moved = idx;
    if (!tie) begin
      if (right ^ foul) begin
        if (idx != LAST_IDX) moved = idx + IW'(1);
      end else begin
        if (idx != '0) moved = idx - IW'(1);
      end
    end
  end

  always_comb begin
    pos = '0;
    pos[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= CTR_IDX;
      cnt   <= '0;
      clr   <= 1'b1;
      win_l <= 1'b0;
      win_r <= 1'b0;
      busy  <= 1'b0;
    end else if (take) begin
      idx <= moved;
      clr <= 1'b1;
      if (moved == '0) begin
        state <= S_WIN;
        win_l <= 1'b1;
        busy  <= 1'b0;
      end else if (moved == LAST_IDX) begin
        state <= S_WIN;
        win_r <= 1'b1;
        busy  <= 1'b0;
      end else begin
        state <= S_HOLD;
        cnt   <= HOLD_LOAD;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ARM;
            cnt   <= ARM_LOAD;
            clr   <= arm_clr;
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (cnt == '0) begin
            state <= S_WAIT;
            clr   <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WAIT: begin
          clr <= 1'b0;
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_ARM;
            cnt   <= ARM_LOAD;
            clr   <= arm_clr;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WIN: begin
          if (start) begin
            state <= S_ARM;
            idx   <= CTR_IDX;
            cnt   <= ARM_LOAD;
            win_l <= 1'b0;
            win_r <= 1'b0;
            clr   <= arm_clr;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= CTR_IDX;
          clr   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
